fir_golden_checker: RTL
=======================

# fir_golden_checker

Self-checking receiver for the 9-tap FIR output stream. It taps the same input stream and coefficients that drive `myfir` and computes the expected output with a bit-exact golden model. Expected samples are queued in a small FIFO and compared, in order, against each valid `DOUT`/`VOUT` the filter produces. It instantiates in `tb_fir` alongside `data_sink`, and also synthesizes for on-board self-test.

## Interface
- `W`, default 12: sample and coefficient width, two's complement.
- `SHIFT`, default 11: right shift applied to the full-precision accumulator to form the output.
- `TOL`, default 1: maximum allowed |DUT − expected| in LSBs.
- `DEPTH`, default 8: expected-sample FIFO depth, power of two.

- `clk` in 1: single clock, rising edge.
- `RST_n` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous clear of counters, flags and FIFO; shift register is kept.
- `VIN` in 1: input sample valid; same net as the FIR `VIN`.
- `din` in W: input sample.
- `B0`..`B8` in W each: coefficients, static while `VIN` activity is ongoing.
- `VOUT_dut` in 1: FIR output valid.
- `DOUT_dut` in W: FIR output sample.
- `mismatch` out 1: one-cycle pulse when a compare fails.
- `exp_q` out W: expected value of the last compare.
- `got_q` out W: DUT value of the last compare.
- `smp_cnt` out 16: compares performed, saturating.
- `err_cnt` out 16: failed compares, saturating.
- `ovf` out 1: sticky, an expected sample was dropped on a full FIFO.
- `unf` out 1: sticky, `VOUT_dut` arrived with no expected sample available.

## Operation
- Golden delay line: 9 × W registers `x0..x8`. On `VIN`=1, `x0`←`din` and `xk`←`x(k-1)`. Otherwise hold. Reset value is 0.
- Golden sum: acc = Σ `xk`·`Bk`, computed from the post-shift values.
  - Each product is signed 2W bits; acc is signed 2W+4 bits with no overflow.
  - Expected value = bits [SHIFT+W-1 : SHIFT] of acc, i.e. truncation toward −∞, no rounding, no saturation.
- Push: the cycle after a `VIN`=1 cycle, the expected value is written to the FIFO. This uses a 1-bit `push_pend` register.
- Pop and compare, when `VOUT_dut`=1 and the FIFO is non-empty:
  - Pop the head.
  - diff = sext(`DOUT_dut`) − sext(head), W+1 bits.
  - Fail if |diff| > TOL.
- FIFO: circular buffer with read and write pointers of log2(DEPTH)+1 bits.
  - Full: MSBs of the pointers differ and the remaining bits are equal.
  - Empty: pointers equal.
- Boundary cases:
  - Push while full with no pop in the same cycle: sample dropped, `ovf`←1, pointers unchanged.
  - Push and pop in the same cycle while full: both occur, and this is legal.
  - Pop while empty: `unf`←1. There is no compare, `smp_cnt` and `err_cnt` are unchanged, and `mismatch` stays 0. A push in the same cycle still writes; there is no bypass.
  - Push and pop in the same cycle while non-empty: occupancy unchanged.
  - Counters saturate at 16'hFFFF and do not wrap. `err_cnt` increments only on a fail; `smp_cnt` increments on every compare.
- `clr`: pointers, counters, `ovf`, `unf`, `mismatch` and `push_pend` go to 0; the delay line is kept. It has priority over simultaneous push and pop.
- Reset mid-stream: everything, including the delay line, goes to 0 immediately; in-flight expectations are discarded.

## Timing
- Reset values: `mismatch`=0, `exp_q`=0, `got_q`=0, `smp_cnt`=0, `err_cnt`=0, `ovf`=0, `unf`=0, FIFO empty.
- `VIN` at cycle n → delay line updated at edge n → expected value in the FIFO at edge n+1. Earliest consumable is `VOUT_dut` at cycle n+2.
- `VOUT_dut` at cycle m → `mismatch`, `exp_q`, `got_q` and the counters update at edge m, visible in cycle m+1.
- `mismatch` is high for exactly one cycle per failed compare; back-to-back fails give back-to-back pulses.
- Throughput: one push and one pop per cycle sustained.
- FIR latency up to DEPTH−2 samples is tolerated without `ovf`.

## Test plan
- Reset, then B0=2047 and all other taps 0, `din`=1024, `VIN` pulse, DUT echoes 1023 two cycles later → expected 1023 (1024·2047>>11), `mismatch`=0, `smp_cnt`=1.
- Same stimulus, DUT returns 1026 → |diff|=3>TOL, `mismatch` pulses once, `err_cnt`=1, `exp_q`=1023, `got_q`=1026; a return of 1024 passes (diff=1).
- Impulse `din`=2047 then zeros, Bk=k·100, 9 `VIN` cycles, DUT model with latency 3 → 9 compares and `err_cnt`=0; negative case `din`=−2048 checks truncation toward −∞.
- 9 `VIN` pulses with `VOUT_dut` held low → `ovf`=1 after the 9th push, FIFO holds 8. Then 8 pops, then one more pop → `unf`=1, `smp_cnt`=8.
- `VIN` every cycle with DUT latency 2 for 100 samples → `smp_cnt`=100 and no `ovf`/`unf`. Assert `RST_n` low mid-burst → all outputs 0 asynchronously and the FIFO is empty.
- `err_cnt` preloaded to 16'hFFFE through forced fails → it reaches 16'hFFFF and holds. `clr` in the same cycle as a push → FIFO empty afterwards, counters 0.

Source files
------------

// File: rtl/fir_golden_checker.sv
// fir_golden_checker: self-checking receiver for the 9-tap FIR output stream.
//
// The block mirrors the FIR input delay line and computes a bit-exact expected output.
// Each expected sample is queued in a small FIFO. Every valid DUT output pops the head and
// compares against it. A difference of more than TOL LSBs is reported as a mismatch.
//
// Ports:
//   clk, RST_n        clock and asynchronous active-low reset
//   clr               synchronous clear of pointers, counters and flags (delay line is kept)
//   VIN, din          input sample stream (same nets that feed the FIR)
//   B0..B8            FIR coefficients (static while samples flow)
//   VOUT_dut, DOUT_dut  FIR output stream under check
//   mismatch          one-cycle pulse per failed compare
//   exp_q, got_q      expected and DUT value of the last compare
//   smp_cnt, err_cnt  saturating compare / failure counters
//   ovf, unf          sticky FIFO overflow / underflow flags
module fir_golden_checker #(
  parameter int unsigned W     = 12,
  parameter int unsigned SHIFT = 11,
  parameter int unsigned TOL   = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         RST_n,
  input  logic         clr,
  input  logic         VIN,
  input  logic [W-1:0] din,
  input  logic [W-1:0] B0,
  input  logic [W-1:0] B1,
  input  logic [W-1:0] B2,
  input  logic [W-1:0] B3,
  input  logic [W-1:0] B4,
  input  logic [W-1:0] B5,
  input  logic [W-1:0] B6,
  input  logic [W-1:0] B7,
  input  logic [W-1:0] B8,
  input  logic         VOUT_dut,
  input  logic [W-1:0] DOUT_dut,
  output logic         mismatch,
  output logic [W-1:0] exp_q,
  output logic [W-1:0] got_q,
  output logic [15:0]  smp_cnt,
  output logic [15:0]  err_cnt,
  output logic         ovf,
  output logic         unf
);

  localparam int          Taps  = 9;
  localparam int unsigned AccW  = 2 * W + 4;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);
  localparam logic [W:0]  TolW   = (W + 1)'(TOL);
  localparam logic [W:0]  DiffOne = (W + 1)'(1);

  // Golden delay line
  logic signed [W-1:0] x_q  [Taps];
  logic signed [W-1:0] coef [Taps];

  always_comb begin
    coef[0] = B0;
    coef[1] = B1;
    coef[2] = B2;
    coef[3] = B3;
    coef[4] = B4;
    coef[5] = B5;
    coef[6] = B6;
    coef[7] = B7;
    coef[8] = B8;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < Taps; k++) x_q[k] <= '0;
    end else if (VIN) begin
      x_q[0] <= din;
      for (int k = 1; k < Taps; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Sum of products from the already-shifted line; sign extension before the multiply
  // keeps every product and the sum exact.
  logic signed [AccW-1:0] acc;
  logic        [W-1:0]    exp_val;

  always_comb begin
    acc = '0;
    for (int k = 0; k < Taps; k++) begin
      acc = acc + AccW'(x_q[k]) * AccW'(coef[k]);
    end
  end

  // Dropping the low SHIFT bits truncates toward minus infinity.
  assign exp_val = acc[SHIFT+W-1:SHIFT];

  // Expected-sample FIFO
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         push_pend_q;
  logic         empty, full, do_pop, do_push;
  logic [W-1:0] head;
  logic [W:0]   diff, abs_diff;
  logic         fail;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = VOUT_dut && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_pend_q && (!full || do_pop);
  assign head    = mem_q[rptr_q[AW-1:0]];

  assign diff     = {DOUT_dut[W-1], DOUT_dut} - {head[W-1], head};
  assign abs_diff = diff[W] ? (~diff + DiffOne) : diff;
  assign fail     = (abs_diff > TolW);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= exp_val;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      push_pend_q <= 1'b0;
      mismatch    <= 1'b0;
      exp_q       <= '0;
      got_q       <= '0;
      smp_cnt     <= '0;
      err_cnt     <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
    end else if (clr) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      push_pend_q <= 1'b0;
      mismatch    <= 1'b0;
      smp_cnt     <= '0;
      err_cnt     <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
    end else begin
      push_pend_q <= VIN;
      mismatch    <= do_pop && fail;
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop) begin
        rptr_q <= rptr_q + PtrOne;
        exp_q  <= head;
        got_q  <= DOUT_dut;
        if (smp_cnt != 16'hFFFF) smp_cnt <= smp_cnt + 16'd1;
        if (fail && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
      if (push_pend_q && full && !do_pop) ovf <= 1'b1;
      if (VOUT_dut && empty) unf <= 1'b1;
    end
  end

endmodule
